// File: rtl/bus_mem_pkg.sv
// Shared definitions for the bus_memory responder.
//   - FSM state encoding (IDLE/BUSY/ACK), exposed on bus_memory.dbg_state
//   - operation encoding (OP_READ/OP_WRITE)
//   - ERR_DATA: read data returned for out-of-range reads (BUS_MEM_RANGE_CHECK_EN builds)
//   - clog2: ceiling log2, used to size the latency counter
package bus_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_mem_ram.sv
// Single-port synchronous RAM behind bus_memory: one write or one read per cycle.
// Ports:
//   clk    in   clock
//   reset  in   sync active-high; clears only the read-data register, never the array
//   we     in   write enable: mem[addr] <= wdata at the rising edge
//   re     in   read enable: rdata <= mem[addr] at the rising edge
//   addr   in   word index [DEPTH_LOG2-1:0]
//   wdata  in   32-bit write data
//   rdata  out  32-bit registered read data; holds its value when re is low
module bus_mem_ram
  import bus_mem_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_memory.sv
// Memory-side responder for the CPU external memory bus.
// Services one word read or write at a time from on-chip RAM with per-op latency.
// Optional feature macro: BUS_MEM_RANGE_CHECK_EN (adds mem_err, flags addresses
// beyond the RAM instead of wrapping them).
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous, active-high
//   mem_read        in   read request, held until ack seen
//   mem_write       in   write request, held until ack seen (wins over mem_read)
//   mem_addr        in   byte address, bits [1:0] ignored
//   mem_write_data  in   write data
//   mem_ack         out  one-cycle registered completion pulse
//   mem_read_data   out  registered read data, valid in ack cycle, held until next read ack
//   mem_err         out  (BUS_MEM_RANGE_CHECK_EN only) qualifies mem_ack: address out of range
//   dbg_state       out  FSM state (bus_mem_pkg ST_*)
//
// Handshake: a request (mem_read|mem_write) acts as "valid" and is accepted on
// the first rising edge it is seen in IDLE; the initiator holds it until it
// samples mem_ack=1. mem_ack is the only "ready": it pulses for exactly one
// cycle per accepted request, LAT cycles after the accepting edge. Inputs are
// ignored from the accept edge until the FSM is back in IDLE.
module bus_memory
  import bus_mem_pkg::*;
#(
  parameter int    DEPTH_LOG2    = 10,
  parameter int    READ_LATENCY  = 2,
  parameter int    WRITE_LATENCY = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic        mem_ack,
  output logic [31:0] mem_read_data,
`ifdef BUS_MEM_RANGE_CHECK_EN
  output logic        mem_err,
`endif
  output logic [1:0]  dbg_state
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LAT_M1 = CNT_W'(WRITE_LATENCY - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  op_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  err_q;

  logic                  req;
  logic                  req_op;
  logic                  req_err;
  logic [CNT_W-1:0]      req_lat_m1;
  logic                  accept;
  logic                  enter_ack;
  logic                  cur_op;
  logic                  cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           cur_wdata;
  logic                  ram_we;
  logic                  ram_re;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_bits;

  assign req        = mem_read | mem_write;
  assign req_op     = mem_write ? OP_WRITE : OP_READ;
  assign req_lat_m1 = (req_op == OP_WRITE) ? WR_LAT_M1 : RD_LAT_M1;
  assign accept     = (state == ST_IDLE) && req;

`ifdef BUS_MEM_RANGE_CHECK_EN
  assign req_err          = |mem_addr[31:DEPTH_LOG2+2];
  assign unused_addr_bits = ^mem_addr[1:0];
`else
  // Upper address bits are dropped: addresses wrap modulo the RAM size.
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};
`endif

  // The RAM access happens on the edge that enters ACK. For a latency-1 op
  // that edge is the accept edge itself, so the live inputs feed the RAM in
  // IDLE and the latched copies feed it from BUSY.
  assign enter_ack = (accept && (req_lat_m1 == '0)) ||
                     ((state == ST_BUSY) && (cnt == CNT_W'(1)));
  assign cur_op    = (state == ST_IDLE) ? req_op                     : op_q;
  assign cur_err   = (state == ST_IDLE) ? req_err                    : err_q;
  assign cur_idx   = (state == ST_IDLE) ? mem_addr[DEPTH_LOG2+1:2]  : idx_q;
  assign cur_wdata = (state == ST_IDLE) ? mem_write_data             : wdata_q;

  // Reset on the would-be ACK edge aborts: no commit, no read update.
  assign ram_we = enter_ack && !reset && (cur_op == OP_WRITE) && !cur_err;
  assign ram_re = enter_ack && !reset && (cur_op == OP_READ)  && !cur_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      mem_ack <= 1'b0;
    end else begin
      mem_ack <= enter_ack;
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q    <= req_op;
            idx_q   <= mem_addr[DEPTH_LOG2+1:2];
            wdata_q <= mem_write_data;
            err_q   <= req_err;
            cnt     <= req_lat_m1;
            state   <= (req_lat_m1 == '0) ? ST_ACK : ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_ACK;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  bus_mem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

`ifdef BUS_MEM_RANGE_CHECK_EN
  // rd_err_q remembers whether the most recent read ack was out of range, so
  // the held read data stays ERR_DATA until the next read ack.
  logic rd_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err  <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      mem_err <= enter_ack && cur_err;
      if (enter_ack && (cur_op == OP_READ)) rd_err_q <= cur_err;
    end
  end

  assign mem_read_data = rd_err_q ? ERR_DATA : ram_rdata;
`else
  assign mem_read_data = ram_rdata;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory.
// dut   : default latencies (read 2, write 1)
// dut_b : read 1, write 3 (gives a write with BUSY cycles for the abort case)
module tb_bus_memory;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

`ifdef BUS_MEM_RANGE_CHECK_EN
  localparam logic [31:0] OOR_RD1  = 32'hDEADBEEF;
  localparam logic        OOR_ERR  = 1'b1;
  localparam logic [31:0] W0_AFTER = 32'h11111111;
  localparam logic [31:0] OOR_RD2  = 32'hDEADBEEF;
`else
  localparam logic [31:0] OOR_RD1  = 32'h11111111;
  localparam logic        OOR_ERR  = 1'b0;
  localparam logic [31:0] W0_AFTER = 32'h77777777;
  localparam logic [31:0] OOR_RD2  = 32'h77777777;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, b_reset;
  logic        mem_read, mem_write, b_read, b_write;
  logic [31:0] mem_addr, mem_write_data, b_addr, b_wdata;
  logic        mem_ack, b_ack;
  logic [31:0] mem_read_data, b_rdata;
  logic [1:0]  dbg_state, b_state;
`ifdef BUS_MEM_RANGE_CHECK_EN
  logic        mem_err, b_err;
`endif

  bus_memory dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_ack        (mem_ack),
    .mem_read_data  (mem_read_data),
`ifdef BUS_MEM_RANGE_CHECK_EN
    .mem_err        (mem_err),
`endif
    .dbg_state      (dbg_state)
  );

  bus_memory #(
    .READ_LATENCY  (1),
    .WRITE_LATENCY (3)
  ) dut_b (
    .clk            (clk),
    .reset          (b_reset),
    .mem_read       (b_read),
    .mem_write      (b_write),
    .mem_addr       (b_addr),
    .mem_write_data (b_wdata),
    .mem_ack        (b_ack),
    .mem_read_data  (b_rdata),
`ifdef BUS_MEM_RANGE_CHECK_EN
    .mem_err        (b_err),
`endif
    .dbg_state      (b_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    bit seen;
    mem_read = v.rd; mem_write = v.wr; mem_addr = v.addr; mem_write_data = v.wdata;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (mem_ack) seen = 1;
    end
    check({tag, "_lat"}, seen ? 32'(n) : 32'hFFFFFFFF, 32'(v.lat));
    check({tag, "_rdata"}, mem_read_data, v.exp_rd);
`ifdef BUS_MEM_RANGE_CHECK_EN
    check({tag, "_err"}, 32'(mem_err), 32'(v.exp_err));
`endif
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(mem_ack), 32'd0);
    check({tag, "_held"}, mem_read_data, v.exp_rd);
    check({tag, "_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic run_b(input vec_t v, input string tag);
    int n;
    bit seen;
    b_read = v.rd; b_write = v.wr; b_addr = v.addr; b_wdata = v.wdata;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (b_ack) seen = 1;
    end
    check({tag, "_lat"}, seen ? 32'(n) : 32'hFFFFFFFF, 32'(v.lat));
    check({tag, "_rdata"}, b_rdata, v.exp_rd);
`ifdef BUS_MEM_RANGE_CHECK_EN
    check({tag, "_err"}, 32'(b_err), 32'(v.exp_err));
`endif
    b_read = 1'b0; b_write = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(b_ack), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    int cyc, k, acks;
    int ack_cyc[3];

    vecs.push_back('{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2, 32'h1234_5678, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1, 32'h1234_5678, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0044, 32'h0,         2, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 1, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, 1, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0FFC, 32'hFEED_FACE, 1, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         2, 32'hFEED_FACE, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 1, 32'hFEED_FACE, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0,         2, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0010_0000, 32'h0,         2, OOR_RD1,       OOR_ERR});
    vecs.push_back('{1'b0, 1'b1, 32'h0010_0000, 32'h7777_7777, 1, OOR_RD1,       OOR_ERR});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0,         2, W0_AFTER,      1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h0,         2, OOR_RD2,       OOR_ERR});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0042, 32'h0,         2, 32'h1234_5678, 1'b0});

    reset = 1'b1; b_reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
    b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; b_reset = 1'b0;

    check("rst_ack", 32'(mem_ack), 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
`ifdef BUS_MEM_RANGE_CHECK_EN
    check("rst_err", 32'(mem_err), 32'd0);
`endif

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("v%0d", i));

    // back-to-back reads, request held, address advanced in the ack cycle
    exp_q.push_back(W0_AFTER);
    exp_q.push_back(32'h2222_2222);
    exp_q.push_back(32'h3333_3333);
    mem_read = 1'b1; mem_addr = 32'h0;
    cyc = 0; k = 0;
    while (k < 3 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (mem_ack) begin
        check($sformatf("b2b_data%0d", k), mem_read_data, exp_q.pop_front());
        ack_cyc[k] = cyc;
        k++;
        if (k < 3) mem_addr = 32'(k * 4);
        else mem_read = 1'b0;
      end
    end
    mem_read = 1'b0;
    check("b2b_acks", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b_first", 32'(ack_cyc[0]), 32'd2);
      check("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      check("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
    end
    @(negedge clk);
    check("b2b_idle", 32'(dbg_state), 32'd0);

    // read request dropped after one BUSY cycle, address changed meanwhile
    mem_read = 1'b1; mem_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    check("drop_busy", 32'(dbg_state), 32'd1);
    mem_read = 1'b0; mem_addr = 32'h44;
    cyc = 0;
    while (!mem_ack && cyc < 10) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check("drop_ack_after", 32'(cyc), 32'd1);
    check("drop_data", mem_read_data, 32'h1234_5678);
    acks = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (mem_ack) acks++;
    end
    check("drop_no_reack", 32'(acks), 32'd0);
    check("drop_idle", 32'(dbg_state), 32'd0);

    // dut_b: write latency 3, read latency 1
    run_b('{1'b0, 1'b1, 32'h80, 32'h5555_AAAA, 3, 32'h0, 1'b0}, "b_wr");
    run_b('{1'b1, 1'b0, 32'h80, 32'h0, 1, 32'h5555_AAAA, 1'b0}, "b_rd");

    // reset on the edge that would commit a latency-3 write
    b_write = 1'b1; b_addr = 32'h80; b_wdata = 32'h9999_9999;
    @(posedge clk); @(negedge clk);
    check("abort_busy1", 32'(b_state), 32'd1);
    @(posedge clk); @(negedge clk);
    check("abort_busy2", 32'(b_state), 32'd1);
    b_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_ack", 32'(b_ack), 32'd0);
    check("abort_state", 32'(b_state), 32'd0);
    check("abort_rdata", b_rdata, 32'd0);
    b_reset = 1'b0; b_write = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (b_ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    run_b('{1'b1, 1'b0, 32'h80, 32'h0, 1, 32'h5555_AAAA, 1'b0}, "b_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
